branch_target_buffer: RTL
=========================

Name: branch_target_buffer

Overview:
- Parametrised, dynamically trained successor to the static branch cache. It is a fully associative table of {PC tag, target, 2-bit direction counter}.
- Lookup is combinational in the fetch stage, so the prediction is available in the same cycle as the PC.
- Training comes from the resolved-branch update port in EX. Misses on taken branches allocate entries, with round-robin replacement once the table is full.
- Handles branches, j and jal only. jr is never presented on the update port.

Parameters:
- ENTRIES, 8, number of table entries; power of two, range 2..64.
- ADDR_W, 32, PC and target width.
- CNT_W, 2, width of the saturating direction counter; minimum 2.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- PC  in  ADDR_W  fetch PC used for lookup.
- PredHit  out  1  a valid entry matches PC.
- PredTaken  out  1  PredHit and the matching counter MSB is 1.
- PredTarget  out  ADDR_W  target of the matching entry; 0 on a miss.
- UpdValid  in  1  a resolved branch/jump is present this cycle.
- UpdPC  in  ADDR_W  PC of the resolved instruction.
- UpdTarget  in  ADDR_W  resolved target address.
- UpdTaken  in  1  resolved direction (1 = taken).
- UpdIsJump  in  1  unconditional j/jal.
- Flush  in  1  synchronous invalidate of all entries.

Behaviour:

Lookup (combinational, zero latency):
- An entry i matches when valid[i] and tag[i] == PC.
- With multiple matches, the lowest index wins.
- On a miss, PredHit = PredTaken = 0 and PredTarget = 0.

Reset (Reset_n low, asynchronous):
- All valid bits = 0.
- Victim pointer = 0.
- Tags, targets and counters = 0.
- As a result all outputs are 0 for any PC during and after reset until training.

Update (on the clock edge with UpdValid = 1):
- Update hit (a valid entry matches UpdPC, lowest index):
  - target <= UpdTarget.
  - If UpdIsJump: counter <= all ones.
  - Otherwise the counter saturates up on UpdTaken and down on not-taken. It stays at all-ones on max+taken and at 0 on 0+not-taken.
  - The victim pointer is unchanged.
- Update miss with UpdTaken = 1 (allocate):
  - Destination is the lowest-index invalid entry if one exists. Otherwise it is the entry at the victim pointer, and the pointer then increments mod ENTRIES.
  - The allocated entry is written with valid = 1, tag = UpdPC, target = UpdTarget.
  - Its counter is all ones if UpdIsJump, else weakly-taken (MSB = 1, rest 0; 2'b10 for CNT_W = 2).
  - The pointer does not move when a free entry is used.
- Update miss with UpdTaken = 0: no state change.

Simultaneous events:
- Lookup and update to the same PC in the same cycle: the lookup returns pre-update state. There is no bypass; the new state is visible from the next cycle.
- Flush and UpdValid in the same cycle: Flush wins.
  - All valid bits are cleared and the victim pointer is reset to 0.
  - The update is dropped.
- Reset_n asserted mid-update: the asynchronous clear takes precedence and no partial write survives.

Width rules:
- Tags compare on the full ADDR_W with no index/offset split.
- The victim pointer is $clog2(ENTRIES) bits wide and wraps naturally.

Decomposition:
- Package btb_pkg holds:
  - counter constants CNT_MAX, CNT_WEAK_TAKEN, CNT_ZERO as functions of CNT_W;
  - a typedef btb_entry_t {valid, tag, target, cnt};
  - a localparam helper for the pointer width.
- One sub-module, btb_sat_counter: combinational next-count logic from (cnt, taken, is_jump) with saturation. It is instantiated once, on the write path.
- Match and priority encoding stay inline.

Test Plan:
- Reset, then sweep PC 0..0x40 -> PredHit = 0, PredTarget = 0 everywhere.
- Update {PC = 0x14, target = 0x10, taken = 1, jump = 0}, then lookup 0x14 -> in the same update cycle PredHit = 0; next cycle PredHit = 1, PredTaken = 1, PredTarget = 0x10. Two not-taken updates -> PredTaken = 0 while PredHit stays 1. Three more not-taken -> counter holds at 0.
- Fill 8 entries with taken branches at 0x100..0x11C, then allocate 0x200 -> overwrites entry 0 (0x100 now misses). Allocate 0x204 -> replaces entry 1. Pointer = 2.
- Jump update {PC = 0x30, target = 0x80, jump = 1} followed by not-taken-free lookups -> PredTaken = 1 with counter = 3. A not-taken miss update at 0x40 -> no allocation, 0x40 still misses.
- Flush asserted together with UpdValid for a new PC 0x50 -> next cycle all lookups miss, including 0x50, and the pointer is 0.
- Drop Reset_n asynchronously between clock edges after training -> PredHit falls immediately without a clock edge. After release, the table is empty.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared constants, entry layout and sizing helpers for the branch target buffer.
package btb_pkg;

    localparam int unsigned BTB_ADDR_W = 32;
    localparam int unsigned BTB_CNT_W  = 2;

    // Entry layout for the default build widths.
    typedef struct packed {
        logic                  valid;
        logic [BTB_ADDR_W-1:0] tag;
        logic [BTB_ADDR_W-1:0] target;
        logic [BTB_CNT_W-1:0]  cnt;
    } btb_entry_t;

    function automatic int unsigned cntMax(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned cntWeakTaken(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    function automatic int unsigned cntZero(input int unsigned w);
        return 32'd0 & w;
    endfunction

    function automatic int unsigned ptrWidth(input int unsigned entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state logic for one saturating direction counter; jumps force it to the maximum.
module btb_sat_counter
    import btb_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    input  logic             isJump,
    output logic [CNT_W-1:0] cntNext
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cntMax(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(cntZero(CNT_W));

    always_comb begin
        cntNext = cnt;
        if (isJump) begin
            cntNext = CNT_MAX;
        end else if (taken) begin
            if (cnt != CNT_MAX) cntNext = cnt + 1'b1;
        end else begin
            if (cnt != CNT_ZERO) cntNext = cnt - 1'b1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer: combinational lookup, trained from resolved
// branches, allocating on taken misses with round-robin replacement once full.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned ADDR_W  = BTB_ADDR_W,
    parameter int unsigned CNT_W   = BTB_CNT_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] PC,
    output logic              PredHit,
    output logic              PredTaken,
    output logic [ADDR_W-1:0] PredTarget,
    input  logic              UpdValid,
    input  logic [ADDR_W-1:0] UpdPC,
    input  logic [ADDR_W-1:0] UpdTarget,
    input  logic              UpdTaken,
    input  logic              UpdIsJump,
    input  logic              Flush
);

    localparam int unsigned      PTR_W          = ptrWidth(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX        = CNT_W'(cntMax(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = CNT_W'(cntWeakTaken(CNT_W));

    logic              valid  [ENTRIES];
    logic [ADDR_W-1:0] tag    [ENTRIES];
    logic [ADDR_W-1:0] target [ENTRIES];
    logic [CNT_W-1:0]  cnt    [ENTRIES];
    logic [PTR_W-1:0]  victimPtr;

    logic             lookHit;
    logic [PTR_W-1:0] lookIdx;
    logic             updHit;
    logic [PTR_W-1:0] updIdx;
    logic             freeFound;
    logic [PTR_W-1:0] freeIdx;
    logic [PTR_W-1:0] allocIdx;
    logic [CNT_W-1:0] hitCntNext;

    // Scan high-to-low so the lowest matching index is the one left standing.
    always_comb begin
        lookHit   = 1'b0;
        lookIdx   = '0;
        updHit    = 1'b0;
        updIdx    = '0;
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == PC) begin
                lookHit = 1'b1;
                lookIdx = PTR_W'(i);
            end
            if (valid[i] && tag[i] == UpdPC) begin
                updHit = 1'b1;
                updIdx = PTR_W'(i);
            end
            if (!valid[i]) begin
                freeFound = 1'b1;
                freeIdx   = PTR_W'(i);
            end
        end
        allocIdx = freeFound ? freeIdx : victimPtr;
    end

    always_comb begin
        PredHit    = lookHit;
        PredTaken  = lookHit && cnt[lookIdx][CNT_W-1];
        PredTarget = lookHit ? target[lookIdx] : '0;
    end

    btb_sat_counter #(
        .CNT_W(CNT_W)
    ) uSatCounter (
        .cnt    (cnt[updIdx]),
        .taken  (UpdTaken),
        .isJump (UpdIsJump),
        .cntNext(hitCntNext)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                cnt[i]    <= '0;
            end
            victimPtr <= '0;
        end else if (Flush) begin
            for (int i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
            victimPtr <= '0;
        end else if (UpdValid) begin
            if (updHit) begin
                target[updIdx] <= UpdTarget;
                cnt[updIdx]    <= hitCntNext;
            end else if (UpdTaken) begin
                valid[allocIdx]  <= 1'b1;
                tag[allocIdx]    <= UpdPC;
                target[allocIdx] <= UpdTarget;
                cnt[allocIdx]    <= UpdIsJump ? CNT_MAX : CNT_WEAK_TAKEN;
                if (!freeFound) victimPtr <= victimPtr + 1'b1;
            end
        end
    end

endmodule
